// File: rtl/imm_pkg.sv
// imm_pkg -- shared types for the immediate-extension pipeline stage.
//
// Contents:
//   imm_src_e  : 3-bit immediate format selector (I/S/B/J/U/Z/SH/reserved).
//   INSTR_W    : instruction word width.
//
// The entry struct (imm, tag, err) depends on XLEN/TAG_W, so it is declared
// inside the module that owns those parameters rather than here.
package imm_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_RSV = 3'b111
  } imm_src_e;

endpackage

// File: rtl/imm_fmt_decode.sv
// imm_fmt_decode -- purely combinational immediate format decode.
//
// Ports:
//   instr    [31:0]     instruction word (opcode bits [6:0] are not used)
//   imm_src  [2:0]      format select, interpreted as imm_src_e
//   imm      [XLEN-1:0] sign- or zero-extended immediate
//   err                 reserved format, or RV32 shamt with instr[25] set
//
// Parameters: XLEN (32 or 64).
module imm_fmt_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         imm_src,
  output logic [XLEN-1:0]    imm,
  output logic               err
);

  // Every format is first assembled as a 32-bit value; sign-extending
  // formats then widen it once, so XLEN=32 never needs a zero-width fill.
  logic [31:0]     v32;
  logic            sext;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;

  // NOTE: every signal written in always_comb gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    v32  = '0;
    sext = 1'b1;
    err  = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_I:  v32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:  v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
      IMM_J:  v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
      IMM_U:  v32 = {instr[31:12], 12'b0};
      IMM_Z: begin
        v32  = {27'b0, instr[19:15]};
        sext = 1'b0;
      end
      IMM_SH: begin
        sext = 1'b0;
        if (XLEN == 64) begin
          v32 = {26'b0, instr[25:20]};
        end else begin
          // RV32 shift amounts are 5 bits; a set instr[25] is illegal.
          v32 = {27'b0, instr[24:20]};
          err = instr[25];
        end
      end
      default: begin
        // Reserved code: defined zero, never X.
        v32  = '0;
        sext = 1'b0;
        err  = 1'b1;
      end
    endcase

    imm_sext = XLEN'($signed(v32));
    imm_zext = XLEN'(v32);
    imm      = sext ? imm_sext : imm_zext;
  end

  // Opcode field is decoded upstream and deliberately ignored here.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe -- pipelined immediate-extension stage with a 2-entry skid
// buffer (main output register + one skid register), full throughput.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   flush               synchronous kill of all buffered entries
//   in_valid/in_ready   upstream handshake (in_ready = !skid_valid, registered)
//   in_instr [31:0]     instruction word
//   in_imm_src [2:0]    format select (imm_src_e)
//   in_tag [TAG_W-1:0]  sideband tag carried with the immediate
//   out_valid/out_ready downstream handshake
//   out_imm [XLEN-1:0]  extended immediate
//   out_tag             tag paired with out_imm
//   out_err             only when IMM_EXT_ERR_EN is defined: illegal format
//
// Parameters: XLEN (32/64), TAG_W.
// Optional feature macro: IMM_EXT_ERR_EN.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_imm_src,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
`ifdef IMM_EXT_ERR_EN
  output logic               out_err,
`endif
  output logic [TAG_W-1:0]   out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } imm_entry_t;

  imm_entry_t new_entry;
  imm_entry_t main_q;
  imm_entry_t skid_q;
  logic       main_valid;
  logic       skid_valid;
  logic       accept;
  logic       drain;

  imm_fmt_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (new_entry.imm),
    .err     (new_entry.err)
  );
  assign new_entry.tag = in_tag;

  // in_ready depends only on the skid flop, so out_ready never reaches it
  // combinationally.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data registers are reset too (not just the valids) so the
      // outputs read zero after reset rather than stale or X values.
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      // Flush beats both accept and drain in the same cycle.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q.err <= 1'b0;
      skid_q.err <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        // Skid refills main; accept is impossible here since in_ready=0.
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else begin
        // Drain and accept together: new entry replaces main, no bubble.
        main_valid <= accept;
        if (accept) main_q <= new_entry;
      end
    end else if (accept) begin
      if (main_valid) begin
        // Main is stalled: park the entry in the skid register.
        skid_q     <= new_entry;
        skid_valid <= 1'b1;
      end else begin
        main_q     <= new_entry;
        main_valid <= 1'b1;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_imm   = main_q.imm;
  assign out_tag   = main_q.tag;

`ifdef IMM_EXT_ERR_EN
  assign out_err = main_q.err;
`else
  // Without the error port the err bit is carried but never observed.
  logic unused_err;
  assign unused_err = main_q.err;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe -- directed self-checking bench for imm_ext_pipe.
// Two instances share all inputs: u32 (XLEN=32) and u64 (XLEN=64).
// Inputs change 1 time unit after the rising edge; outputs are checked
// there too, away from the active edge.
module tb_imm_ext_pipe;

  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready32, out_valid32;
  logic [31:0]      out_imm32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag64;
`ifdef IMM_EXT_ERR_EN
  logic             out_err32, out_err64;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(TAG_W)) u32 (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready32),
    .in_instr   (in_instr),
    .in_imm_src (in_imm_src),
    .in_tag     (in_tag),
    .out_valid  (out_valid32),
    .out_ready  (out_ready),
    .out_imm    (out_imm32),
`ifdef IMM_EXT_ERR_EN
    .out_err    (out_err32),
`endif
    .out_tag    (out_tag32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(TAG_W)) u64 (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready64),
    .in_instr   (in_instr),
    .in_imm_src (in_imm_src),
    .in_tag     (in_tag),
    .out_valid  (out_valid64),
    .out_ready  (out_ready),
    .out_imm    (out_imm64),
`ifdef IMM_EXT_ERR_EN
    .out_err    (out_err64),
`endif
    .out_tag    (out_tag64)
  );

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] src,
                       input logic [31:0] instr, input logic [7:0] tag);
    in_valid   = v;
    in_imm_src = src;
    in_instr   = instr;
    in_tag     = tag;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 8'h00);
    #2;
    check("reset_out_valid", 64'(out_valid32), 64'd0);
    check("reset_in_ready",  64'(in_ready32),  64'd1);
    check("reset_out_imm",   64'(out_imm32),   64'd0);
    check("reset_out_tag",   64'(out_tag32),   64'd0);
    step();
    reset = 1'b0;
    step();

    // Back-to-back formats with out_ready=1: one result per cycle.
    drive(1'b1, 3'b000, 32'hFFF00093, 8'h11);            // I
    step();
    check("i_valid", 64'(out_valid32), 64'd1);
    check("i_imm32", 64'(out_imm32),   64'hFFFFFFFF);
    check("i_tag",   64'(out_tag32),   64'h11);
    check("i_imm64", out_imm64,        64'hFFFFFFFFFFFFFFFF);
    drive(1'b1, 3'b010, 32'hFE000EE3, 8'h22);            // B
    step();
    check("b_imm32", 64'(out_imm32), 64'hFFFFFFFC);
    check("b_tag",   64'(out_tag32), 64'h22);
    drive(1'b1, 3'b011, 32'h0080006F, 8'h33);            // J
    step();
    check("j_imm32", 64'(out_imm32), 64'h00000008);
    drive(1'b1, 3'b100, 32'h123452B7, 8'h44);            // U
    step();
    check("u_imm32", 64'(out_imm32), 64'h12345000);
    check("u_imm64", out_imm64,      64'h0000000012345000);
    drive(1'b1, 3'b100, 32'h800002B7, 8'h45);            // U, negative
    step();
    check("u_neg_imm64", out_imm64, 64'hFFFFFFFF80000000);
    drive(1'b1, 3'b001, 32'h80000023, 8'h55);            // S
    step();
    check("s_imm32", 64'(out_imm32), 64'hFFFFF800);
    drive(1'b1, 3'b101, 32'hFFFF8073, 8'h66);            // Z: [19:15]=31
    step();
    check("z_imm32", 64'(out_imm32), 64'd31);
    check("z_imm64", out_imm64,      64'd31);
    drive(1'b1, 3'b110, 32'h03F01093, 8'h77);            // SH
    step();
    check("sh_imm32", 64'(out_imm32), 64'd31);
    check("sh_imm64", out_imm64,      64'd63);
`ifdef IMM_EXT_ERR_EN
    check("sh_err32", 64'(out_err32), 64'd1);
    check("sh_err64", 64'(out_err64), 64'd0);
`endif
    drive(1'b1, 3'b111, 32'hFFFFFFFF, 8'h88);            // reserved
    step();
    check("rsv_imm32", 64'(out_imm32), 64'd0);
    check("rsv_imm64", out_imm64,      64'd0);
    check("rsv_tag",   64'(out_tag32), 64'h88);
`ifdef IMM_EXT_ERR_EN
    check("rsv_err32", 64'(out_err32), 64'd1);
`endif
    drive(1'b0, 3'b000, 32'h0, 8'h00);
    step();
    check("idle_valid", 64'(out_valid32), 64'd0);

    // Backpressure: tags 1,2,3 with out_ready=0.
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00100093, 8'h01);
    step();
    check("bp_t1_valid",  64'(out_valid32), 64'd1);
    check("bp_t1_ready",  64'(in_ready32),  64'd1);
    drive(1'b1, 3'b000, 32'h00200093, 8'h02);
    step();
    check("bp_t2_ready",  64'(in_ready32),  64'd0);
    check("bp_t2_tag",    64'(out_tag32),   64'h01);
    drive(1'b1, 3'b000, 32'h00300093, 8'h03);            // held upstream
    step();
    check("bp_hold_tag",  64'(out_tag32),   64'h01);
    check("bp_hold_imm",  64'(out_imm32),   64'd1);
    check("bp_hold_rdy",  64'(in_ready32),  64'd0);
    out_ready = 1'b1;
    step();
    check("bp_out2_tag",  64'(out_tag32),   64'h02);
    check("bp_out2_imm",  64'(out_imm32),   64'd2);
    check("bp_out2_rdy",  64'(in_ready32),  64'd1);
    step();                                              // tag 3 accepted
    check("bp_out3_tag",  64'(out_tag32),   64'h03);
    check("bp_out3_imm",  64'(out_imm32),   64'd3);
    drive(1'b0, 3'b000, 32'h0, 8'h00);
    step();
    check("bp_empty",     64'(out_valid32), 64'd0);

    // Flush with both registers full and in_valid=1.
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h04100093, 8'h41);
    step();
    drive(1'b1, 3'b000, 32'h04200093, 8'h42);
    step();
    check("fl_full_rdy",  64'(in_ready32),  64'd0);
    flush = 1'b1;
    drive(1'b1, 3'b000, 32'h04300093, 8'h43);
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 8'h00);
    check("fl_valid",     64'(out_valid32), 64'd0);
    check("fl_ready",     64'(in_ready32),  64'd1);
    out_ready = 1'b1;
    step();
    check("fl_stay_empty", 64'(out_valid32), 64'd0);

    // Flush with main full and skid empty: the input in the flush cycle
    // is discarded even though in_ready=1.
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h05100093, 8'h51);
    step();
    flush = 1'b1;
    drive(1'b1, 3'b000, 32'h05200093, 8'h52);
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 8'h00);
    check("fl2_valid",    64'(out_valid32), 64'd0);
    out_ready = 1'b1;

    // Asynchronous reset mid-stream while out_valid=1.
    drive(1'b1, 3'b000, 32'h06100093, 8'h61);
    step();
    check("ar_pre_valid", 64'(out_valid32), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid",     64'(out_valid32), 64'd0);
    check("ar_ready",     64'(in_ready32),  64'd1);
    check("ar_imm",       64'(out_imm32),   64'd0);
    check("ar_tag",       64'(out_tag32),   64'd0);
    drive(1'b0, 3'b000, 32'h0, 8'h00);
    step();
    reset = 1'b0;
    step();
    check("ar_rel_ready", 64'(in_ready32),  64'd1);
    drive(1'b1, 3'b000, 32'hFFE00093, 8'h71);            // I: -2
    step();
    drive(1'b0, 3'b000, 32'h0, 8'h00);
    check("ar_i_valid",   64'(out_valid32), 64'd1);
    check("ar_i_imm",     64'(out_imm32),   64'hFFFFFFFE);
    check("ar_i_tag",     64'(out_tag32),   64'h71);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
